// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared constants and types for the seven-segment scan
// decoder. Segment patterns are active-low {a,b,c,d,e,f,g} in bits 6..0.
package seg_scan_pkg;

  // Segment patterns produced by the display encoder.
  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  // Glyph "0" exists on the panel but is not part of the status code table.
  localparam logic [6:0] SEG_0      = 7'b0000001;
  localparam logic [6:0] SEG_1      = 7'b1001111;
  localparam logic [6:0] SEG_2      = 7'b0010010;
  localparam logic [6:0] SEG_3      = 7'b0000110;
  localparam logic [6:0] SEG_4      = 7'b1001100;
  localparam logic [6:0] SEG_5      = 7'b0100100;
  localparam logic [6:0] SEG_6      = 7'b0100000;
  localparam logic [6:0] SEG_7      = 7'b0001111;
  localparam logic [6:0] SEG_8      = 7'b0000000;
  localparam logic [6:0] SEG_9      = 7'b0000100;
  localparam logic [6:0] SEG_STABLE = 7'b1111110;
  localparam logic [6:0] SEG_UP     = 7'b1000001;
  localparam logic [6:0] SEG_DOWN   = 7'b0001001;

  // Display codes recovered from the patterns.
  localparam logic [3:0] CODE_BLANK  = 4'd0;
  localparam logic [3:0] CODE_STABLE = 4'd10;
  localparam logic [3:0] CODE_UP     = 4'd11;
  localparam logic [3:0] CODE_DOWN   = 4'd12;
  localparam logic [3:0] CODE_ERR    = 4'd15;

  // Dwell counter width; the stability threshold is capped to fit it.
  localparam int CNT_W = 8;

  // Scan FSM encodings, kept fixed so captured state values stay comparable
  // with older capture logs.
  localparam logic [1:0] ST_IDLE_ENC     = 2'd0;
  localparam logic [1:0] ST_SETTLE_ENC   = 2'd1;
  localparam logic [1:0] ST_CAPTURED_ENC = 2'd2;

  typedef enum logic [1:0] {
    SCAN_IDLE     = ST_IDLE_ENC,
    SCAN_SETTLE   = ST_SETTLE_ENC,
    SCAN_CAPTURED = ST_CAPTURED_ENC
  } scan_state_e;

  // Saturating increment of the dwell counter.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] cnt,
                                                   input logic [CNT_W-1:0] limit);
    logic [CNT_W-1:0] res;
    if (cnt >= limit) begin
      res = limit;
    end else begin
      res = cnt + 8'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: combinational inverse of the display encoder table.
// Maps an active-low segment pattern to its 4-bit code; unknown patterns
// (including the plain "0" glyph) return CODE_ERR with err set.
module seg_pattern_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       err
);

  // Pattern lookup; every entry not listed is an error pattern.
  always_comb begin
    code = CODE_ERR;
    err  = 1'b1;
    case (seg)
      SEG_BLANK:  begin code = CODE_BLANK;  err = 1'b0; end
      SEG_1:      begin code = 4'd1;        err = 1'b0; end
      SEG_2:      begin code = 4'd2;        err = 1'b0; end
      SEG_3:      begin code = 4'd3;        err = 1'b0; end
      SEG_4:      begin code = 4'd4;        err = 1'b0; end
      SEG_5:      begin code = 4'd5;        err = 1'b0; end
      SEG_6:      begin code = 4'd6;        err = 1'b0; end
      SEG_7:      begin code = 4'd7;        err = 1'b0; end
      SEG_8:      begin code = 4'd8;        err = 1'b0; end
      SEG_9:      begin code = 4'd9;        err = 1'b0; end
      SEG_STABLE: begin code = CODE_STABLE; err = 1'b0; end
      SEG_UP:     begin code = CODE_UP;     err = 1'b0; end
      SEG_DOWN:   begin code = CODE_DOWN;   err = 1'b0; end
      default:    begin code = CODE_ERR;    err = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: reads back a multiplexed active-low seven-segment bus,
// debounces each anode dwell, decodes it into a per-digit frame register and
// offers each capture as an event on a single-entry valid/ready port.
//
// Build option: define SEG_SCAN_CHANGE_ONLY_EN to emit events only when a
// capture changes the stored code of its digit (frame updates are the same
// in both builds).
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_DIGITS-1:0]         an_in,
  input  logic [6:0]                    seg_in,
  output logic [4*NUM_DIGITS-1:0]       code_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(NUM_DIGITS)-1:0] out_digit,
  output logic [3:0]                    out_code,
  output logic                          out_err,
  output logic                          overflow
);

  localparam int DIG_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);

`ifdef SEG_SCAN_CHANGE_ONLY_EN
  localparam logic CHANGE_ONLY = 1'b1;
`else
  localparam logic CHANGE_ONLY = 1'b0;
`endif

  // True when exactly one anode line is driven low.
  function automatic logic onehot_low(input logic [NUM_DIGITS-1:0] an);
    logic [3:0] zeros;
    zeros = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      zeros = zeros + {3'b000, ~an[i]};
    end
    return (zeros == 4'd1);
  endfunction

  // Registered copies of the pins and all state.
  logic [NUM_DIGITS-1:0]   s_an_r;
  logic [6:0]              s_seg_r;
  scan_state_e             state_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [4*NUM_DIGITS-1:0] code_out_r;
  logic                    out_valid_r;
  logic [DIG_W-1:0]        out_digit_r;
  logic [3:0]              out_code_r;
  logic                    out_err_r;
  logic                    overflow_r;

  // Combinational next-state and decode signals.
  scan_state_e             state_nx_s;
  logic [CNT_W-1:0]        cnt_nx_s;
  logic [CNT_W-1:0]        cnt_inc_s;
  logic                    capture_s;
  logic                    cur_valid_s;
  logic                    same_s;
  logic [DIG_W-1:0]        dig_idx_s;
  logic [3:0]              dec_code_s;
  logic                    dec_err_s;
  logic [3:0]              slot_code_s;
  logic                    slot_diff_s;
  logic                    ev_fire_s;
  logic [4*NUM_DIGITS-1:0] code_nx_s;

  // The FSM judges the sample entering the input register against the one
  // already held, so a value counts as sampled on the edge that registers
  // it and a capture lands STABLE_CYCLES edges after the pins settle.
  assign cur_valid_s = onehot_low(an_in);
  assign same_s      = ({an_in, seg_in} == {s_an_r, s_seg_r});
  assign cnt_inc_s   = cnt_sat_inc(cnt_r, STABLE_CNT);

  seg_pattern_decode u_decode (
    .seg  (s_seg_r),
    .code (dec_code_s),
    .err  (dec_err_s)
  );

  // Input stage: register the display pins every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_an_r  <= {NUM_DIGITS{1'b1}};
      s_seg_r <= 7'b1111111;
    end else begin
      s_an_r  <= an_in;
      s_seg_r <= seg_in;
    end
  end

  // Dwell FSM: track stability of the lit digit and flag the capture edge.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    capture_s  = 1'b0;
    case (state_r)
      SCAN_IDLE: begin
        if (cur_valid_s) begin
          state_nx_s = SCAN_SETTLE;
          cnt_nx_s   = 8'd1;
        end else begin
          state_nx_s = SCAN_IDLE;
          cnt_nx_s   = 8'd0;
        end
      end
      SCAN_SETTLE: begin
        if (same_s) begin
          cnt_nx_s = cnt_inc_s;
          if (cnt_inc_s >= STABLE_CNT) begin
            capture_s  = 1'b1;
            state_nx_s = SCAN_CAPTURED;
          end else begin
            state_nx_s = SCAN_SETTLE;
          end
        end else if (cur_valid_s) begin
          state_nx_s = SCAN_SETTLE;
          cnt_nx_s   = 8'd1;
        end else begin
          state_nx_s = SCAN_IDLE;
          cnt_nx_s   = 8'd0;
        end
      end
      SCAN_CAPTURED: begin
        if (same_s) begin
          state_nx_s = SCAN_CAPTURED;
          cnt_nx_s   = cnt_r;
        end else if (cur_valid_s) begin
          state_nx_s = SCAN_SETTLE;
          cnt_nx_s   = 8'd1;
        end else begin
          state_nx_s = SCAN_IDLE;
          cnt_nx_s   = 8'd0;
        end
      end
      default: begin
        state_nx_s = SCAN_IDLE;
        cnt_nx_s   = 8'd0;
      end
    endcase
  end

  // FSM state and dwell counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= SCAN_IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Index of the lit anode; only meaningful while the anode is one-hot-low.
  always_comb begin
    dig_idx_s = {DIG_W{1'b0}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!s_an_r[i]) begin
        dig_idx_s = DIG_W'(i);
      end else begin
        dig_idx_s = dig_idx_s;
      end
    end
  end

  // Currently stored code of the lit digit, and the frame after a capture.
  always_comb begin
    slot_code_s = 4'd0;
    code_nx_s   = code_out_r;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_idx_s == DIG_W'(i)) begin
        slot_code_s = code_out_r[4*i +: 4];
        if (capture_s) begin
          code_nx_s[4*i +: 4] = dec_code_s;
        end else begin
          code_nx_s[4*i +: 4] = code_out_r[4*i +: 4];
        end
      end else begin
        code_nx_s[4*i +: 4] = code_out_r[4*i +: 4];
      end
    end
  end

  // Error captures store CODE_ERR, so comparing codes also covers err.
  assign slot_diff_s = (dec_code_s != slot_code_s);
  assign ev_fire_s   = capture_s && (!CHANGE_ONLY || slot_diff_s);

  // Frame register: one 4-bit slot per digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      code_out_r <= {(4*NUM_DIGITS){1'b0}};
    end else begin
      code_out_r <= code_nx_s;
    end
  end

  // Event holding register: load when empty or being drained, else drop
  // the new event and latch the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_digit_r <= {DIG_W{1'b0}};
      out_code_r  <= 4'd0;
      out_err_r   <= 1'b0;
      overflow_r  <= 1'b0;
    end else if (ev_fire_s) begin
      if (!out_valid_r || out_ready) begin
        out_valid_r <= 1'b1;
        out_digit_r <= dig_idx_s;
        out_code_r  <= dec_code_s;
        out_err_r   <= dec_err_s;
      end else begin
        overflow_r  <= 1'b1;
      end
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign code_out  = code_out_r;
  assign out_valid = out_valid_r;
  assign out_digit = out_digit_r;
  assign out_code  = out_code_r;
  assign out_err   = out_err_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scenarios plus randomized dwells, checked
// against a reference model of the dwell/capture/event rules with a queue
// scoreboard drained by an independent monitor.
module tb_seg_scan_decoder;

  localparam int ND     = 4;
  localparam int STABLE = 4;
  localparam int DW     = 2;
`ifdef SEG_SCAN_CHANGE_ONLY_EN
  localparam bit CHG = 1'b1;
`else
  localparam bit CHG = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [ND-1:0]   an_in;
  logic [6:0]      seg_in;
  logic [4*ND-1:0] code_out;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_digit;
  logic [3:0]      out_code;
  logic            out_err;
  logic            overflow;

  seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .reset(reset), .an_in(an_in), .seg_in(seg_in),
    .code_out(code_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_digit(out_digit), .out_code(out_code), .out_err(out_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [DW-1:0] dig; logic [3:0] code; logic err; } ev_t;
  ev_t q[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_pop = 0;
  logic [3:0] last_code;
  logic       last_err;
  bit mon_en = 1'b0;
  int ready_mode = 0;   // 0: always ready, 1: never ready, 2: random

  // Reference model state.
  logic [4*ND-1:0] m_frame;
  logic            m_pending;
  logic            m_ovf;
  logic [ND+6:0]   m_prev;
  int              m_run;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoder table: code -> pattern.
  function automatic logic [6:0] pat_of(input int c);
    case (c)
      0: return 7'b1111111;   1: return 7'b1001111;  2: return 7'b0010010;
      3: return 7'b0000110;   4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;   7: return 7'b0001111;  8: return 7'b0000000;
      9: return 7'b0000100;  10: return 7'b1111110; 11: return 7'b1000001;
      12: return 7'b0001001;
      default: return 7'b0000001;
    endcase
  endfunction

  // Reference model: advanced once per clock edge.
  initial begin
    m_frame = '0; m_pending = 1'b0; m_ovf = 1'b0; m_prev = '1; m_run = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_frame = '0; m_pending = 1'b0; m_ovf = 1'b0; m_prev = '1; m_run = 0;
        q.delete();
      end else begin
        logic [ND+6:0] cur;
        bit fire, accept;
        ev_t ev;
        cur = {an_in, seg_in};
        if (cur == m_prev) m_run = (m_run < 1000) ? m_run + 1 : m_run;
        else m_run = 1;
        m_prev = cur;
        accept = m_pending && out_ready;
        fire = 1'b0;
        if (m_run == STABLE && $countones(~an_in) == 1) begin
          ev.dig = '0;
          for (int i = 0; i < ND; i++) if (!an_in[i]) ev.dig = DW'(i);
          ev.code = 4'hF; ev.err = 1'b1;
          for (int c = 0; c <= 12; c++)
            if (pat_of(c) == seg_in) begin ev.code = 4'(c); ev.err = 1'b0; end
          fire = !CHG || (m_frame[4*ev.dig +: 4] != ev.code);
          m_frame[4*ev.dig +: 4] = ev.code;
          if (fire) begin
            if (!m_pending || accept) begin m_pending = 1'b1; q.push_back(ev); end
            else m_ovf = 1'b1;
          end
        end
        if (!fire && accept) m_pending = 1'b0;
      end
    end
  end

  // Monitor: compare port, frame and overflow each cycle; pop on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("valid", out_valid, m_pending);
        chk("frame", code_out, m_frame);
        chk("overflow", overflow, m_ovf);
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_event", {out_digit, out_code, out_err}, 32'h0);
            n_errors += (n_checks > 0 && {out_digit, out_code, out_err} == 7'h0) ? 1 : 0;
          end else begin
            ev_t e;
            e = q.pop_front();
            chk("ev_digit", out_digit, e.dig);
            chk("ev_code", out_code, e.code);
            chk("ev_err", out_err, e.err);
          end
          n_pop++;
          last_code = out_code;
          last_err  = out_err;
        end
      end
    end
  end

  // Consumer ready driver.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Hold an anode/segment pair for n clock edges (call at posedge+1).
  task automatic dwell(input logic [ND-1:0] an, input logic [6:0] seg, input int n);
    an_in = an; seg_in = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    dwell(4'b1111, 7'b1111111, n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int p0;
    int digs[4];
    an_in = 4'b1111; seg_in = 7'b1111111; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;

    // Reset state.
    chk("rst_code_out", code_out, 32'h0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_digit", out_digit, 2'd0);
    chk("rst_code", out_code, 4'd0);
    chk("rst_err", out_err, 1'b0);
    chk("rst_overflow", overflow, 1'b0);

    // Single digit: capture latency and hold without ready.
    ready_mode = 1;
    idle(2);
    an_in = 4'b1110; seg_in = 7'b0010010;
    for (int j = 1; j <= 10; j++) begin
      @(posedge clk); #1;
      chk("t1_valid", out_valid, (j >= STABLE) ? 1'b1 : 1'b0);
    end
    chk("t1_slot0", code_out[3:0], 4'd2);
    chk("t1_payload", {out_digit, out_code, out_err}, {2'd0, 4'd2, 1'b0});
    ready_mode = 0;
    idle(4);

    // Full scan with codes 1, 11, 12, 9.
    p0 = n_pop;
    dwell(4'b1110, 7'b1001111, 8);
    dwell(4'b1101, 7'b1000001, 8);
    dwell(4'b1011, 7'b0001001, 8);
    dwell(4'b0111, 7'b0000100, 8);
    idle(3);
    chk("t2_frame", code_out, 16'h9CB1);
    chk("t2_events", n_pop - p0, 4);

    // Short dwell is ignored.
    p0 = n_pop;
    dwell(4'b1101, 7'b0100100, 3);
    idle(3);
    chk("t3_frame", code_out, 16'h9CB1);
    chk("t3_events", n_pop - p0, 0);

    // Unknown pattern on digit 2.
    dwell(4'b1011, 7'b0000001, 8);
    idle(3);
    chk("t4_frame", code_out, 16'h9FB1);
    chk("t4_code", last_code, 4'hF);
    chk("t4_err", last_err, 1'b1);

    // Backpressure: second event dropped, overflow sticky.
    ready_mode = 1;
    idle(2);
    dwell(4'b1110, 7'b0000110, 8);
    dwell(4'b1101, 7'b1001100, 8);
    idle(2);
    chk("t5_overflow", overflow, 1'b1);
    chk("t5_held", {out_valid, out_digit, out_code}, {1'b1, 2'd0, 4'd3});
    chk("t5_frame", code_out, 16'h9F43);
    ready_mode = 0;
    idle(4);
    chk("t5_overflow_sticky", overflow, 1'b1);
    chk("t5_drained", out_valid, 1'b0);
    do_reset();
    chk("t5_rst_overflow", overflow, 1'b0);
    chk("t5_rst_frame", code_out, 16'h0);

    // Same frame scanned twice.
    digs = '{2, 5, 7, 10};
    p0 = n_pop;
    for (int r = 0; r < 2; r++)
      for (int d = 0; d < 4; d++)
        dwell(~(4'b0001 << d), pat_of(digs[d]), 6);
    idle(3);
    chk("t6_frame", code_out, 16'hA752);
    chk("t6_events", n_pop - p0, CHG ? 4 : 8);

    // Randomized dwells with random backpressure and occasional reset.
    ready_mode = 2;
    for (int it = 0; it < 400; it++) begin
      logic [ND-1:0] an;
      logic [6:0] seg;
      int sel;
      sel = $urandom_range(0, 7);
      if (sel < 6) an = ~(4'b0001 << $urandom_range(0, 3));
      else if (sel == 6) an = 4'b1111;
      else an = 4'($urandom);
      if ($urandom_range(0, 4) != 0) seg = pat_of($urandom_range(0, 12));
      else seg = 7'($urandom);
      dwell(an, seg, $urandom_range(1, 9));
      if ($urandom_range(0, 79) == 0) do_reset();
    end
    ready_mode = 0;
    idle(12);
    chk("final_queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
